// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared constants and transfer type for the data-memory port arbiter
package dm_arb_pkg;
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
  localparam int DM_RD_LATENCY = 1;
  localparam logic [31:0] IO_BASE = 32'h8000_0000;
  localparam logic [3:0] DM_BE_NONE = 4'b0000;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        sgn;
  } dm_xfer_t;
endpackage

// File: rtl/dm_port_arbiter_if.sv
// dm_port_arbiter_if: requester A/B handshakes plus the mmu data-memory port
interface dm_port_arbiter_if;
  logic        a_req, a_we, a_signed, a_gnt, a_rvalid;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_be;
  logic        b_req, b_we, b_signed, b_gnt, b_rvalid;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [3:0]  b_be;
  logic        dm_we, is_signed, contended;
  logic [31:0] dm_addr, dm_di, dm_do;
  logic [3:0]  dm_be;
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, a_be, a_signed,
    input  b_req, b_we, b_addr, b_wdata, b_be, b_signed, dm_do,
    output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
    output dm_we, dm_addr, dm_di, dm_be, is_signed, contended
  );
  modport master (
    output a_req, a_we, a_addr, a_wdata, a_be, a_signed,
    output b_req, b_we, b_addr, b_wdata, b_be, b_signed, dm_do,
    input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
    input  dm_we, dm_addr, dm_di, dm_be, is_signed, contended
  );
endinterface

// File: rtl/dm_arb_grant.sv
// dm_arb_grant: A-priority grant with a bounded hold that forces B in after MAX_HOLD contended losses
module dm_arb_grant #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt,
  output logic b_gnt
);
  logic [HOLD_W-1:0] hold_cnt;
  logic              force_b;
  assign force_b = hold_cnt >= HOLD_W'(MAX_HOLD);
  assign a_gnt   = !reset && a_req && !(b_req && force_b);
  assign b_gnt   = !reset && b_req && (!a_req || force_b);
  always_ff @(posedge clk) begin
    if (reset || !b_req || b_gnt) hold_cnt <= '0;
    else if (a_gnt) hold_cnt <= hold_cnt + 1'b1;
  end
endmodule

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the mmu data-memory port between the LSU (A) and the debug loader (B)
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input logic clk,
  input logic reset,
  dm_port_arbiter_if.slave p
);
  logic     a_gnt, b_gnt, rd_pend, rd_owner, a_rv, b_rv;
  dm_xfer_t a_x, b_x, sel;
  dm_arb_grant #(.MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) u_grant (
    .clk(clk), .reset(reset), .a_req(p.a_req), .b_req(p.b_req), .a_gnt(a_gnt), .b_gnt(b_gnt)
  );
  assign a_x = '{p.a_we, p.a_addr, p.a_wdata, p.a_be, p.a_signed};
  assign b_x = '{p.b_we, p.b_addr, p.b_wdata, p.b_be, p.b_signed};
  always_comb sel = b_gnt ? b_x : a_gnt ? a_x : '{we: 1'b0, addr: '0, wdata: '0, be: DM_BE_NONE, sgn: 1'b0};
  assign p.a_gnt     = a_gnt;
  assign p.b_gnt     = b_gnt;
  assign p.dm_we     = sel.we;
  assign p.dm_addr   = sel.addr;
  assign p.dm_di     = sel.wdata;
  assign p.dm_be     = sel.be;
  assign p.is_signed = sel.sgn;
  assign p.contended = p.a_req && p.b_req;
  // the single outstanding read returns dm_do one cycle after its grant
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      rd_owner <= REQ_A;
    end else begin
      rd_pend  <= (a_gnt || b_gnt) && !sel.we;
      rd_owner <= b_gnt ? REQ_B : REQ_A;
    end
  end
  // reset in the return cycle squashes the rvalid of the read granted just before it
  assign a_rv       = rd_pend && rd_owner == REQ_A && !reset;
  assign b_rv       = rd_pend && rd_owner == REQ_B && !reset;
  assign p.a_rvalid = a_rv;
  assign p.b_rvalid = b_rv;
  assign p.a_rdata  = a_rv ? p.dm_do : '0;
  assign p.b_rdata  = b_rv ? p.dm_do : '0;
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: directed plus randomized check of dm_port_arbiter against a behavioural model
module tb_dm_port_arbiter;
  import dm_arb_pkg::*;
  localparam int MAX_HOLD = 8;
  logic clk_tb = 1'b0;
  logic reset = 1'b1;
  always #5 clk_tb = ~clk_tb;
  dm_port_arbiter_if bus();
  dm_port_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(8)) dut (.clk(clk_tb), .reset(reset), .p(bus));
  int n_pass = 0, n_total = 0;
  logic [31:0] mmu_mem[32];
  logic [31:0] ref_mem[32];
  logic init_done = 1'b0;
  logic e_ag, e_bg, e_we, e_sg;
  logic [31:0] e_addr, e_di;
  logic [3:0] e_be;
  int m_lost = 0;
  logic m_pend = 1'b0, m_owner = 1'b0;
  logic [31:0] m_data = '0;
  function automatic int idx(logic [31:0] a);
    return int'({a[31], a[5:2]});
  endfunction
  function automatic logic [31:0] bemask(logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  // mmu stand-in: word memory preloaded with word i = i, dm_do one cycle after the address
  always @(posedge clk_tb) begin
    if (!init_done) for (int i = 0; i < 32; i++) mmu_mem[i] <= 32'(i);
    else if (bus.dm_we)
      mmu_mem[idx(bus.dm_addr)] <= (mmu_mem[idx(bus.dm_addr)] & ~bemask(bus.dm_be)) | (bus.dm_di & bemask(bus.dm_be));
    bus.dm_do <= mmu_mem[idx(bus.dm_addr)];
  end
  // reference model: m_lost counts B's consecutive contended losses, m_* holds the pending read
  always @(negedge clk_tb) begin
    e_ag   = !reset && bus.a_req && !(bus.b_req && m_lost >= MAX_HOLD);
    e_bg   = !reset && bus.b_req && (!bus.a_req || m_lost >= MAX_HOLD);
    e_we   = e_ag ? bus.a_we : e_bg ? bus.b_we : 1'b0;
    e_addr = e_ag ? bus.a_addr : e_bg ? bus.b_addr : 32'h0;
    e_di   = e_ag ? bus.a_wdata : e_bg ? bus.b_wdata : 32'h0;
    e_be   = e_ag ? bus.a_be : e_bg ? bus.b_be : 4'h0;
    e_sg   = e_ag ? bus.a_signed : e_bg ? bus.b_signed : 1'b0;
    chk("a_gnt", bus.a_gnt, e_ag);
    chk("b_gnt", bus.b_gnt, e_bg);
    chk("dm_we", bus.dm_we, e_we);
    chk("dm_addr", bus.dm_addr, e_addr);
    chk("dm_di", bus.dm_di, e_di);
    chk("dm_be", bus.dm_be, e_be);
    chk("is_signed", bus.is_signed, e_sg);
    chk("contended", bus.contended, bus.a_req && bus.b_req);
    chk("a_rvalid", bus.a_rvalid, !reset && m_pend && !m_owner);
    chk("b_rvalid", bus.b_rvalid, !reset && m_pend && m_owner);
    chk("a_rdata", bus.a_rdata, (!reset && m_pend && !m_owner) ? m_data : 32'h0);
    chk("b_rdata", bus.b_rdata, (!reset && m_pend && m_owner) ? m_data : 32'h0);
  end
  always @(posedge clk_tb) begin
    if (!init_done) for (int i = 0; i < 32; i++) ref_mem[i] <= 32'(i);
    init_done <= 1'b1;
    if (reset) begin
      m_lost <= 0;
      m_pend <= 1'b0;
    end else begin
      if (e_we) ref_mem[idx(e_addr)] <= (ref_mem[idx(e_addr)] & ~bemask(e_be)) | (e_di & bemask(e_be));
      m_pend  <= (e_ag || e_bg) && !e_we;
      m_owner <= e_bg;
      m_data  <= ref_mem[idx(e_addr)];
      m_lost  <= (!bus.b_req || e_bg) ? 0 : e_ag ? m_lost + 1 : m_lost;
    end
  end
  task automatic nxt;
    @(posedge clk_tb);
    #1;
  endtask
  task automatic mid;
    @(negedge clk_tb);
  endtask
  task automatic drv(input bit side, input logic r, input logic we, input logic [31:0] ad,
                     input logic [31:0] wd, input logic [3:0] be, input logic sg);
    if (!side) begin
      bus.a_req = r; bus.a_we = we; bus.a_addr = ad; bus.a_wdata = wd; bus.a_be = be; bus.a_signed = sg;
    end else begin
      bus.b_req = r; bus.b_we = we; bus.b_addr = ad; bus.b_wdata = wd; bus.b_be = be; bus.b_signed = sg;
    end
  endtask
  task automatic rnd(input bit side);
    logic [31:0] ad;
    ad = ($urandom_range(0, 1) != 0 ? IO_BASE : 32'h1000_0000) + 32'(4 * $urandom_range(0, 15));
    drv(side, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ad, $urandom,
        4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
  endtask
  // both sides held requesting right after reset release: B wins on cycles 9 and 18
  task automatic contend(input string tag);
    for (int c = 1; c <= 18; c++) begin
      mid;
      chk({tag, " b_gnt"}, bus.b_gnt, 32'(c == 9 || c == 18));
      chk({tag, " contended"}, bus.contended, 1);
      nxt;
    end
  endtask
  initial begin
    logic ag, bg;
    drv(0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    nxt;
    drv(0, 1, 1, 32'h1000_0000, 32'hdead_beef, 4'hf, 0);
    mid;
    chk("rst a_gnt", bus.a_gnt, 0);
    chk("rst dm_we", bus.dm_we, 0);
    nxt;
    reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    mid;
    chk("idle dm_be", bus.dm_be, 0);
    chk("idle a_rvalid", bus.a_rvalid, 0);
    nxt;
    for (int i = 0; i < 8; i++) begin
      drv(1, 1, 0, 32'h1000_0000 + 32'(4 * i), 0, 4'hf, 0);
      mid;
      chk("pipe b_gnt", bus.b_gnt, 1);
      if (i > 0) begin
        chk("pipe b_rvalid", bus.b_rvalid, 1);
        chk("pipe b_rdata", bus.b_rdata, 32'(i - 1));
      end
      nxt;
    end
    drv(1, 0, 0, 0, 0, 0, 0);
    mid;
    chk("pipe last b_rdata", bus.b_rdata, 7);
    nxt;
    for (int i = 0; i < 6; i++) begin
      drv(i[0], 1, 0, i[0] ? 32'h1000_0008 : 32'h1000_0004, 0, 4'hf, 0);
      drv(!i[0], 0, 0, 0, 0, 0, 0);
      mid;
      if (i > 0 && i[0]) begin
        chk("ilv a_rdata", bus.a_rdata, 1);
        chk("ilv b_rdata", bus.b_rdata, 0);
      end
      if (i > 0 && !i[0]) begin
        chk("ilv b_rdata", bus.b_rdata, 2);
        chk("ilv a_rdata", bus.a_rdata, 0);
      end
      nxt;
    end
    drv(0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0);
    nxt;
    drv(0, 1, 1, 32'h1000_0000, 32'h1234_5678, 4'hf, 0);
    mid;
    chk("wr a_gnt", bus.a_gnt, 1);
    nxt;
    drv(0, 1, 0, 32'h1000_0000, 0, 4'hf, 0);
    mid;
    chk("rd a_gnt", bus.a_gnt, 1);
    nxt;
    drv(0, 0, 0, 0, 0, 0, 0);
    mid;
    chk("rd a_rvalid", bus.a_rvalid, 1);
    chk("rd a_rdata", bus.a_rdata, 32'h1234_5678);
    chk("rd b_rvalid", bus.b_rvalid, 0);
    nxt;
    drv(0, 1, 1, 32'h8000_0004, 32'h5, 4'hf, 0);
    mid;
    chk("io dm_we", bus.dm_we, 1);
    chk("io dm_addr", bus.dm_addr, 32'h8000_0004);
    nxt;
    drv(0, 0, 0, 0, 0, 0, 0);
    mid;
    chk("io idle dm_we", bus.dm_we, 0);
    chk("io idle dm_be", bus.dm_be, 0);
    nxt;
    drv(0, 1, 0, 32'h1000_0000, 0, 4'hf, 0);
    drv(1, 1, 0, 32'h1000_0004, 0, 4'hf, 0);
    reset = 1'b1;
    mid;
    chk("rst both a_gnt", bus.a_gnt, 0);
    chk("rst both b_gnt", bus.b_gnt, 0);
    nxt;
    reset = 1'b0;
    contend("cont");
    drv(1, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 0, 32'h1000_000c, 0, 4'hf, 0);
    mid;
    chk("rstrd a_gnt", bus.a_gnt, 1);
    nxt;
    reset = 1'b1;
    drv(0, 1, 1, 32'h1000_0010, 32'h99, 4'hf, 0);
    drv(1, 1, 1, 32'h1000_0014, 32'h77, 4'hf, 0);
    mid;
    chk("rstrd a_rvalid", bus.a_rvalid, 0);
    chk("rstrd gnts", {bus.a_gnt, bus.b_gnt}, 0);
    chk("rstrd dm_we", bus.dm_we, 0);
    nxt;
    reset = 1'b0;
    drv(0, 1, 0, 32'h1000_0010, 0, 4'hf, 0);
    drv(1, 1, 0, 32'h1000_0014, 0, 4'hf, 0);
    contend("rst");
    for (int n = 0; n < 3000; n++) begin
      mid;
      ag = bus.a_gnt;
      bg = bus.b_gnt;
      nxt;
      reset = $urandom_range(0, 199) == 0;
      if (!bus.a_req || ag) rnd(0);
      if (!bus.b_req || bg) rnd(1);
    end
    reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0);
    repeat (3) nxt;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
